sap_accumulator_alu: RTL and testbench
======================================

Name: sap_accumulator_alu

Overview:
- Parametrised next-generation SAP accumulator.
- Keeps the SAP-1 accumulator role: holds the A value, feeds the adder path, and drives the W bus on enable.
- Adds the following on top of that role:
  - internal single-cycle ops: load, add, sub, shift-left, shift-right;
  - a multi-cycle shift-add multiply with busy/done handshake;
  - carry/zero/negative flags;
  - optional saturating add/sub.
- Sits between the W bus, the controller-sequencer (la/ea/op strobes) and the output register.

Parameters:
- WIDTH, 8, data/accumulator width in bits (legal range 4..32).
- SATURATE, 0, 1 = ADD/SUB clamp to all-ones / zero instead of wrapping.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  operand from the W bus.
- op  input  3  operation select:
  - 000 LOAD, 001 ADD, 010 SUB, 011 SHL, 100 SHR, 101 MUL;
  - 110 and 111 are NOP.
- la  input  1  active-high execute strobe; sampled on the rising edge.
- ea  input  1  active-high bus-drive enable.
- toadder  output  WIDTH  current accumulator value, always driven.
- todataout  output  WIDTH  accumulator value when ea=1, otherwise high-Z.
- acc_hi  output  WIDTH  upper half of the last MUL product; 0 after any other op.
- busy  output  1  high while a MUL is in progress.
- done  output  1  one-cycle pulse on op completion.
- flag_c  output  1  carry / borrow / shift-out / overflow flag.
- flag_z  output  1  accumulator equals zero.
- flag_n  output  1  accumulator MSB.

Behaviour:
- Reset:
  - clr_n low immediately forces acc, acc_hi, multiplier, counter, busy, done and all flags to 0; state returns to IDLE.
  - This includes an abort of any MUL in flight.
  - todataout follows ea, so it reads 0 when ea=1 during reset.
- States: IDLE and MUL. The FSM is idle whenever busy=0.
- IDLE, la=1 with a single-cycle op (LOAD/ADD/SUB/SHL/SHR): acc updates on that same edge, flags update, and done=1 for the next cycle.
  - LOAD: acc=data_in; flag_c unchanged.
  - ADD: acc=acc+data_in; flag_c=carry-out.
    - SATURATE=1: on carry, acc=all-ones and flag_c=1.
  - SUB: acc=acc-data_in; flag_c=1 when acc>=data_in (no borrow).
    - SATURATE=1: on borrow, acc=0 and flag_c=0.
  - SHL: acc={acc[WIDTH-2:0],0}; flag_c=old acc[WIDTH-1].
  - SHR (logical): acc={0,acc[WIDTH-1:1]}; flag_c=old acc[0].
  - acc_hi is cleared by every non-MUL op that executes.
- IDLE, la=1 with op=NOP: no state change; done pulses anyway, so the controller never stalls.
- IDLE, la=1 with op=MUL (unsigned acc × data_in):
  - Edge E0: latch multiplicand=acc and multiplier=data_in; clear the 2×WIDTH partial product; counter=0; busy=1; enter MUL.
  - Edges E1..E_WIDTH: one shift-add step per edge, LSB of the multiplier first.
  - At E_WIDTH:
    - acc=product[WIDTH-1:0], acc_hi=product[2W-1:W];
    - flag_c=(acc_hi!=0); flags Z/N computed from the new acc;
    - busy=0, done=1 for one cycle; return to IDLE.
  - During MUL, acc and toadder hold the pre-MUL value until E_WIDTH.
- la while busy=1: ignored, with no queueing. la at the same edge where busy falls is also ignored.
  - The controller must wait for done before re-strobing.
- flag_z and flag_n always reflect the acc value written by the last completed op. LOAD updates Z/N.
- ea is independent of the FSM: the bus may be driven during MUL and shows the held acc.
- done never coincides with busy=1.
- Width rules:
  - All ADD/SUB arithmetic is WIDTH+1 bits internally.
  - The multiply accumulator is 2×WIDTH bits.
  - Counter width is clog2(WIDTH)+1.

Test Plan:
- Reset/LOAD (WIDTH=8):
  - LOAD 0x3C -> toadder=0x3C, done pulse 1 cycle, Z=0, N=0.
  - With ea=0 -> todataout=Z; with ea=1 -> todataout=0x3C.
- ADD wrap vs saturate:
  - acc=0xF0 ADD 0x20, SATURATE=0 -> acc=0x10, C=1.
  - Same with SATURATE=1 -> acc=0xFF, C=1.
  - acc=0x80 ADD 0x80 (SAT=0) -> acc=0x00, Z=1, C=1.
- SUB/shift:
  - acc=0x05 SUB 0x07 -> acc=0xFE, C=0, N=1 (SAT=1 -> acc=0x00, Z=1).
  - acc=0x81: SHL -> 0x02, C=1; then SHR -> 0x01, C=0.
- MUL:
  - acc=0x0F MUL 0x11 -> busy high for 8 cycles after the strobe edge, acc=0xFF, acc_hi=0x00, C=0, done 1 cycle.
  - acc=0xFF MUL 0xFF -> acc=0x01, acc_hi=0xFE, C=1.
- Handshake collisions:
  - la=1 ADD issued mid-MUL and on the busy-fall edge -> ignored; acc shows only the MUL result.
  - NOP strobe -> done pulse, nothing else changes.
- Reset mid-operation:
  - clr_n low at MUL step 4 -> acc, acc_hi, busy, done and flags all 0 immediately (asynchronously).
  - After release, LOAD 0xAA works normally.

Source files
------------

// File: rtl/sap_accumulator_alu.sv
// SAP accumulator with single-cycle ALU ops, a shift-add multiplier and C/Z/N flags.
// Drives the adder path continuously and the W bus when ea is high.
module sap_accumulator_alu #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       op,
  input  logic             la,
  input  logic             ea,
  output logic [WIDTH-1:0] toadder,
  output logic [WIDTH-1:0] todataout,
  output logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_MUL  = 3'd5
  } op_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 c_q, c_d;
  logic                 z_q, z_d;
  logic                 n_q, n_d;
  logic                 commit;

  // Bit WIDTH of sum is the carry-out; bit WIDTH of diff is the borrow.
  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   prod_step;

  assign sum       = {1'b0, acc_q} + {1'b0, data_in};
  assign diff      = {1'b0, acc_q} - {1'b0, data_in};
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    acc_hi_d = acc_hi_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    commit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (la) begin
          case (op)
            OP_LOAD: begin
              acc_d    = data_in;
              acc_hi_d = '0;
              commit   = 1'b1;
            end
            OP_ADD: begin
              acc_d    = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
              c_d      = sum[WIDTH];
              acc_hi_d = '0;
              commit   = 1'b1;
            end
            OP_SUB: begin
              acc_d    = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
              c_d      = ~diff[WIDTH];
              acc_hi_d = '0;
              commit   = 1'b1;
            end
            OP_SHL: begin
              acc_d    = {acc_q[WIDTH-2:0], 1'b0};
              c_d      = acc_q[WIDTH-1];
              acc_hi_d = '0;
              commit   = 1'b1;
            end
            OP_SHR: begin
              acc_d    = {1'b0, acc_q[WIDTH-1:1]};
              c_d      = acc_q[0];
              acc_hi_d = '0;
              commit   = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = {{WIDTH{1'b0}}, acc_q};
              mplier_d = data_in;
              prod_d   = '0;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_MUL;
            end
            default: done_d = 1'b1;  // NOP still acknowledges the strobe
          endcase
        end
      end

      S_MUL: begin
        // la is deliberately not looked at here, including on the final step.
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          acc_d    = prod_step[WIDTH-1:0];
          acc_hi_d = prod_step[2*WIDTH-1:WIDTH];
          c_d      = |prod_step[2*WIDTH-1:WIDTH];
          busy_d   = 1'b0;
          state_d  = S_IDLE;
          commit   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      z_d    = (acc_d == '0);
      n_d    = acc_d[WIDTH-1];
      done_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      acc_hi_q <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      acc_hi_q <= acc_hi_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign toadder   = acc_q;
  assign todataout = ea ? acc_q : {WIDTH{1'bz}};
  assign acc_hi    = acc_hi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;

endmodule

// File: tb/tb_sap_accumulator_alu.sv
// Bench for sap_accumulator_alu: wrapping and saturating instances share one stimulus
// stream and are compared every cycle against an arithmetic model, plus literal spot checks.
module tb_sap_accumulator_alu;

  localparam int W    = 8;
  localparam int MAXV = 2 ** W;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [W-1:0] data_in;
  logic [2:0]   op;
  logic         la;
  logic         ea;

  logic [W-1:0] toadder_w, acc_hi_w, toadder_s, acc_hi_s;
  wire  [W-1:0] tod_w, tod_s;
  logic         busy_w, done_w, c_w, z_w, n_w;
  logic         busy_s, done_s, c_s, z_s, n_s;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

  sap_accumulator_alu #(.WIDTH(W), .SATURATE(1'b0)) dut_w (
    .clk(clk), .clr_n(clr_n), .data_in(data_in), .op(op), .la(la), .ea(ea),
    .toadder(toadder_w), .todataout(tod_w), .acc_hi(acc_hi_w), .busy(busy_w),
    .done(done_w), .flag_c(c_w), .flag_z(z_w), .flag_n(n_w)
  );

  sap_accumulator_alu #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .clr_n(clr_n), .data_in(data_in), .op(op), .la(la), .ea(ea),
    .toadder(toadder_s), .todataout(tod_s), .acc_hi(acc_hi_s), .busy(busy_s),
    .done(done_s), .flag_c(c_s), .flag_z(z_s), .flag_n(n_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 wraps, index 1 saturates. A MUL is one product plus a
  // countdown of W edges before it becomes visible.
  int m_acc[2], m_hi[2], m_left[2], m_prod[2];
  bit m_c[2], m_z[2], m_n[2], m_done[2];
  int s_tmp, d_int;
  bit fin, sat;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_hi[i] = 0; m_left[i] = 0; m_prod[i] = 0;
        m_c[i] = 0; m_z[i] = 0; m_n[i] = 0; m_done[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sat = (i == 1);
        fin = 1'b0;
        d_int = int'(data_in);
        m_done[i] = 1'b0;
        if (m_left[i] > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_acc[i] = m_prod[i] % MAXV;
            m_hi[i]  = m_prod[i] / MAXV;
            m_c[i]   = (m_hi[i] != 0);
            fin = 1'b1;
          end
        end else if (la) begin
          case (op)
            OP_LOAD: begin m_acc[i] = d_int; m_hi[i] = 0; fin = 1'b1; end
            OP_ADD: begin
              s_tmp = m_acc[i] + d_int;
              m_c[i] = (s_tmp >= MAXV);
              m_acc[i] = (s_tmp >= MAXV) ? (sat ? MAXV - 1 : s_tmp - MAXV) : s_tmp;
              m_hi[i] = 0; fin = 1'b1;
            end
            OP_SUB: begin
              m_c[i] = (m_acc[i] >= d_int);
              m_acc[i] = m_c[i] ? m_acc[i] - d_int : (sat ? 0 : m_acc[i] - d_int + MAXV);
              m_hi[i] = 0; fin = 1'b1;
            end
            OP_SHL: begin
              m_c[i] = (m_acc[i] >= MAXV / 2);
              m_acc[i] = (m_acc[i] * 2) % MAXV;
              m_hi[i] = 0; fin = 1'b1;
            end
            OP_SHR: begin
              m_c[i] = (m_acc[i] % 2 == 1);
              m_acc[i] = m_acc[i] / 2;
              m_hi[i] = 0; fin = 1'b1;
            end
            OP_MUL: begin m_prod[i] = m_acc[i] * d_int; m_left[i] = W; end
            default: m_done[i] = 1'b1;
          endcase
        end
        if (fin) begin
          m_done[i] = 1'b1;
          m_z[i] = (m_acc[i] == 0);
          m_n[i] = (m_acc[i] >= MAXV / 2);
        end
      end
    end
  end

  task automatic cmp(input int i, input logic [W-1:0] ta, input logic [W-1:0] hi,
                     input logic [W-1:0] tod, input logic b, input logic d,
                     input logic c, input logic z, input logic n);
    check($sformatf("toadder[%0d]", i), ta, m_acc[i]);
    check($sformatf("acc_hi[%0d]", i), hi, m_hi[i]);
    check($sformatf("busy[%0d]", i), b, (m_left[i] > 0));
    check($sformatf("done[%0d]", i), d, m_done[i]);
    check($sformatf("flag_c[%0d]", i), c, m_c[i]);
    check($sformatf("flag_z[%0d]", i), z, m_z[i]);
    check($sformatf("flag_n[%0d]", i), n, m_n[i]);
    check($sformatf("done_busy_excl[%0d]", i), d & b, 0);
    if (ea) check($sformatf("todataout[%0d]", i), tod, m_acc[i]);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      #1;
      cmp(0, toadder_w, acc_hi_w, tod_w, busy_w, done_w, c_w, z_w, n_w);
      cmp(1, toadder_s, acc_hi_s, tod_s, busy_s, done_s, c_s, z_s, n_s);
    end
  end

  task automatic strobe(input logic [2:0] o, input logic [W-1:0] d);
    @(negedge clk);
    op = o; data_in = d; la = 1'b1;
    @(negedge clk);
    la = 1'b0;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int busy_cycles;
  int guard;

  initial begin
    clr_n = 1'b0; la = 1'b0; ea = 1'b0; op = OP_NOP; data_in = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_toadder", toadder_w, 0);
    check("rst_acc_hi", acc_hi_w, 0);
    check("rst_busy", busy_w, 0);
    check("rst_done", done_w, 0);
    check("rst_flags", {c_w, z_w, n_w}, 0);
    ea = 1'b1; #1;
    check("rst_todataout_ea1", tod_w, 0);
    ea = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    run_cmp = 1'b1;

    // LOAD and bus drive
    strobe(OP_LOAD, 8'h3C);
    check("load_toadder", toadder_w, 8'h3C);
    check("load_done", done_w, 1);
    check("load_zn", {z_w, n_w}, 0);
    check("ea0_not_driving", (tod_w !== 8'h3C), 1);
    ea = 1'b1; #1;
    check("ea1_todataout", tod_w, 8'h3C);
    ea = 1'b0;
    @(negedge clk); #2;
    check("load_done_pulse_end", done_w, 0);

    // ADD wrap vs saturate
    strobe(OP_LOAD, 8'hF0);
    strobe(OP_ADD, 8'h20);
    check("add_wrap_acc", toadder_w, 8'h10);
    check("add_wrap_c", c_w, 1);
    check("add_sat_acc", toadder_s, 8'hFF);
    check("add_sat_c", c_s, 1);
    strobe(OP_LOAD, 8'h80);
    strobe(OP_ADD, 8'h80);
    check("add_zero_acc", toadder_w, 8'h00);
    check("add_zero_zc", {z_w, c_w}, 2'b11);

    // SUB and shifts
    strobe(OP_LOAD, 8'h05);
    strobe(OP_SUB, 8'h07);
    check("sub_wrap_acc", toadder_w, 8'hFE);
    check("sub_wrap_cn", {c_w, n_w}, 2'b01);
    check("sub_sat_acc", toadder_s, 8'h00);
    check("sub_sat_zc", {z_s, c_s}, 2'b10);
    strobe(OP_LOAD, 8'h81);
    strobe(OP_SHL, 8'h00);
    check("shl_acc", toadder_w, 8'h02);
    check("shl_c", c_w, 1);
    strobe(OP_SHR, 8'h00);
    check("shr_acc", toadder_w, 8'h01);
    check("shr_c", c_w, 0);

    // MUL 0x0F * 0x11 with busy-length measurement
    strobe(OP_LOAD, 8'h0F);
    strobe(OP_MUL, 8'h11);
    check("mul_acc_held", toadder_w, 8'h0F);
    busy_cycles = 0; guard = 0;
    while (!done_w && guard < 40) begin
      if (busy_w) busy_cycles++;
      @(negedge clk); #2;
      guard++;
    end
    check("mul1_done_seen", done_w, 1);
    check("mul1_busy_cycles", busy_cycles, W);
    check("mul1_acc", toadder_w, 8'hFF);
    check("mul1_acc_hi", acc_hi_w, 8'h00);
    check("mul1_c", c_w, 0);
    @(negedge clk); #2;
    check("mul1_done_pulse_end", done_w, 0);

    // MUL 0xFF * 0xFF with ADD strobes mid-run and on the busy-fall edge
    strobe(OP_LOAD, 8'hFF);
    @(negedge clk);
    op = OP_MUL; data_in = 8'hFF; la = 1'b1;
    @(negedge clk);
    op = OP_ADD; data_in = 8'h01; la = 1'b0;
    for (int k = 1; k <= W; k++) begin
      la = (k == 3 || k == W);
      @(negedge clk);
    end
    la = 1'b0;
    #2;
    check("mul2_done", done_w, 1);
    check("mul2_busy", busy_w, 0);
    check("mul2_acc", toadder_w, 8'h01);
    check("mul2_acc_hi", acc_hi_w, 8'hFE);
    check("mul2_c", c_w, 1);
    @(negedge clk); #2;
    check("mul2_add_ignored", toadder_w, 8'h01);

    // NOP: done pulse only
    strobe(OP_NOP, 8'h55);
    check("nop_done", done_w, 1);
    check("nop_acc", toadder_w, 8'h01);
    check("nop_acc_hi", acc_hi_w, 8'hFE);

    // Reset in the middle of a MUL
    strobe(OP_LOAD, 8'h03);
    @(negedge clk);
    op = OP_MUL; data_in = 8'h05; la = 1'b1;
    @(negedge clk);
    la = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("abort_toadder", toadder_w, 0);
    check("abort_acc_hi", acc_hi_w, 0);
    check("abort_busy", busy_w, 0);
    check("abort_done", done_w, 0);
    check("abort_flags", {c_w, z_w, n_w}, 0);
    check("abort_busy_sat", busy_s, 0);
    @(negedge clk);
    clr_n = 1'b1;
    strobe(OP_LOAD, 8'hAA);
    check("post_reset_load", toadder_w, 8'hAA);
    check("post_reset_n", n_w, 1);
    check("post_reset_done", done_w, 1);

    repeat (3) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
